// File: rtl/mips_pipe_control.sv
// Pipeline control for the 4-stage MIPS datapath (IF, ID, EX, MEM/WB).
// Decodes the ID-stage opcode into the ID/EX control word, inserts a bubble
// on a load-use hazard, squashes younger slots after a taken branch resolves
// in MEM, and keeps saturating stall/flush event counters.
//
// Control word layout:
//   [8] RegDst  [7] Branch  [6] MemRead  [5] MemToReg  [4] MemWrite
//   [3] RegWrite  [2] ALUSrc  [1:0] ALUOp
module mips_pipe_control #(
  parameter int unsigned FLUSH_DEPTH = 3,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             branch_taken,
  output logic [8:0]       control,
  output logic             stall,
  output logic             flush,
  output logic             illegal_op,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned FcntW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [FcntW-1:0] FcntInit = FcntW'(FLUSH_DEPTH - 1);

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;

  localparam logic [8:0] CtrlRtype = 9'b1_0000_1000;
  localparam logic [8:0] CtrlLw    = 9'b0_0110_1101;
  localparam logic [8:0] CtrlSw    = 9'b0_0001_0110;
  localparam logic [8:0] CtrlBeq   = 9'b0_1000_0011;

  typedef enum logic [0:0] {
    StRun,
    StFlush
  } state_e;

  state_e           state_q, state_d;
  logic [FcntW-1:0] fcnt_q, fcnt_d;
  logic             ex_memread_q, ex_memread_d;
  logic [4:0]       ex_dest_q, ex_dest_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [8:0] dec_ctrl;
  logic       dec_legal;
  logic       hazard;

  // Raw opcode decode, before any bubble/squash gating.
  always_comb begin
    dec_ctrl  = '0;
    dec_legal = 1'b1;
    unique case (opcode)
      OpRtype: dec_ctrl = CtrlRtype;
      OpLw:    dec_ctrl = CtrlLw;
      OpSw:    dec_ctrl = CtrlSw;
      OpBeq:   dec_ctrl = CtrlBeq;
      default: dec_legal = 1'b0;
    endcase
  end

  // Load-use hazard: the load now in EX writes a register the ID instruction
  // may read. rt is compared even for non-reading opcodes (conservative).
  always_comb begin
    hazard = (state_q == StRun) && ex_memread_q && (ex_dest_q != 5'd0) &&
             ((ex_dest_q == id_rs) || (ex_dest_q == id_rt));
  end

  // Output decode: stall/flush per state, then gate the issued control word.
  always_comb begin
    stall = 1'b0;
    flush = 1'b0;
    unique case (state_q)
      StRun: begin
        // A taken branch squashes the ID instruction, so no stall is needed.
        flush = branch_taken;
        stall = ~branch_taken & hazard;
      end
      StFlush: flush = 1'b1;
      default: ;
    endcase
    if (reset) begin
      stall = 1'b0;
      flush = 1'b0;
    end
    illegal_op = ~reset & (state_q == StRun) & ~dec_legal;
    control    = (reset | stall | flush | illegal_op) ? 9'd0 : dec_ctrl;
  end

  // Next-state logic for the FSM, hazard tracking and event counters.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    // Track what was actually issued, so a bubble clears the load marker.
    ex_memread_d = control[6];
    ex_dest_d    = id_rt;
    unique case (state_q)
      StRun: begin
        if (branch_taken) begin
          state_d = StFlush;
          fcnt_d  = FcntInit;
          if (flush_cnt_q != {CNT_W{1'b1}}) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
          end
        end else if (hazard) begin
          if (stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
          end
        end
      end
      StFlush: begin
        // In-flight slots are bubbles, so branch_taken is not looked at here.
        if (fcnt_q == '0) begin
          state_d = StRun;
        end else begin
          fcnt_d = fcnt_q - FcntW'(1);
        end
      end
      default: state_d = StRun;
    endcase
  end

  // State register with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRun;
      fcnt_q       <= '0;
      ex_memread_q <= 1'b0;
      ex_dest_q    <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      ex_memread_q <= ex_memread_d;
      ex_dest_q    <= ex_dest_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_mips_pipe_control.sv
// Bench for mips_pipe_control: directed vectors with literal checks plus a
// behavioural model compared against two instances (16-bit and 2-bit counters).
module tb_mips_pipe_control;

  localparam int unsigned FD = 3;
  localparam int unsigned W  = 16;
  localparam int unsigned WS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic [4:0]    id_rs, id_rt;
  logic          branch_taken;
  logic [8:0]    control, control_s;
  logic          stall, stall_s, flush, flush_s, illegal_op, illegal_s;
  logic [W-1:0]  stall_count, flush_count;
  logic [WS-1:0] stall_count_s, flush_count_s;

  always #5 clk = ~clk;

  mips_pipe_control #(.FLUSH_DEPTH(FD), .CNT_W(W)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .branch_taken (branch_taken),
    .control      (control),
    .stall        (stall),
    .flush        (flush),
    .illegal_op   (illegal_op),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  mips_pipe_control #(.FLUSH_DEPTH(FD), .CNT_W(WS)) u_sat (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .branch_taken (branch_taken),
    .control      (control_s),
    .stall        (stall_s),
    .flush        (flush_s),
    .illegal_op   (illegal_s),
    .stall_count  (stall_count_s),
    .flush_count  (flush_count_s)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_flushing;
  int         m_left;
  bit         m_prev_load;
  logic [4:0] m_prev_rt;
  int         m_stalls, m_flushes;

  function automatic logic [8:0] decode(input logic [5:0] op);
    case (op)
      6'h00:   return 9'h108;
      6'h23:   return 9'h06D;
      6'h2B:   return 9'h016;
      6'h04:   return 9'h083;
      default: return 9'h000;
    endcase
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04);
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic expect_now(output logic [8:0] e_ctrl, output bit e_stall, output bit e_flush,
                            output bit e_ill, output bit e_haz);
    e_haz   = !m_flushing && m_prev_load && (m_prev_rt != 5'd0) &&
              ((m_prev_rt == id_rs) || (m_prev_rt == id_rt));
    e_flush = !reset && (m_flushing || branch_taken);
    e_stall = !reset && !m_flushing && !branch_taken && e_haz;
    e_ill   = !reset && !m_flushing && !is_legal(opcode);
    e_ctrl  = (reset || e_stall || e_flush || e_ill) ? 9'h000 : decode(opcode);
  endtask

  always @(posedge clk or posedge reset) begin
    logic [8:0] ec;
    bit es, ef, ei, eh;
    if (reset) begin
      m_flushing  <= 1'b0;
      m_left      <= 0;
      m_prev_load <= 1'b0;
      m_prev_rt   <= 5'd0;
      m_stalls    <= 0;
      m_flushes   <= 0;
    end else begin
      expect_now(ec, es, ef, ei, eh);
      m_prev_load <= ec[6];
      m_prev_rt   <= id_rt;
      if (m_flushing) begin
        if (m_left == 0) m_flushing <= 1'b0;
        else m_left <= m_left - 1;
      end else if (branch_taken) begin
        m_flushing <= 1'b1;
        m_left     <= FD - 1;
        m_flushes  <= m_flushes + 1;
      end else if (eh) begin
        m_stalls <= m_stalls + 1;
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [8:0] ec;
    bit es, ef, ei, eh;
    if (run_cmp) begin
      expect_now(ec, es, ef, ei, eh);
      check("model control", 32'(control), 32'(ec));
      check("model stall", 32'(stall), 32'(es));
      check("model flush", 32'(flush), 32'(ef));
      check("model illegal_op", 32'(illegal_op), 32'(ei));
      check("model stall_count", 32'(stall_count), 32'(sat(m_stalls, W)));
      check("model flush_count", 32'(flush_count), 32'(sat(m_flushes, W)));
      check("model sat control", 32'(control_s), 32'(ec));
      check("model sat stall", 32'(stall_s), 32'(es));
      check("model sat flush", 32'(flush_s), 32'(ef));
      check("model sat illegal_op", 32'(illegal_s), 32'(ei));
      check("model sat stall_count", 32'(stall_count_s), 32'(sat(m_stalls, WS)));
      check("model sat flush_count", 32'(flush_count_s), 32'(sat(m_flushes, WS)));
    end
  end

  // ---------------- directed stimulus ----------------
  // Apply inputs just after a posedge, then move to just after the next negedge.
  task automatic cyc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic bt);
    @(posedge clk);
    #1;
    opcode       = op;
    id_rs        = rs;
    id_rt        = rt;
    branch_taken = bt;
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    opcode       = 6'h00;
    id_rs        = 5'd1;
    id_rt        = 5'd2;
    branch_taken = 1'b0;
    run_cmp      = 1'b1;

    // Reset: outputs held quiet even with a decodable opcode present.
    @(negedge clk);
    #1;
    check("reset control", 32'(control), 32'h0);
    check("reset stall", 32'(stall), 32'h0);
    check("reset flush", 32'(flush), 32'h0);
    check("reset stall_count", 32'(stall_count), 32'h0);
    opcode = 6'h3F;
    #1;
    check("reset illegal_op", 32'(illegal_op), 32'h0);
    reset = 1'b0;

    // Decode sweep.
    cyc(6'h00, 5'd1, 5'd2, 1'b0);
    check("rtype control", 32'(control), 32'h108);
    check("rtype illegal_op", 32'(illegal_op), 32'h0);
    cyc(6'h23, 5'd1, 5'd3, 1'b0);
    check("lw control", 32'(control), 32'h06D);
    cyc(6'h2B, 5'd4, 5'd5, 1'b0);
    check("sw control", 32'(control), 32'h016);
    check("sw stall", 32'(stall), 32'h0);
    cyc(6'h04, 5'd6, 5'd7, 1'b0);
    check("beq control", 32'(control), 32'h083);
    cyc(6'h3F, 5'd0, 5'd0, 1'b0);
    check("bad control", 32'(control), 32'h0);
    check("bad illegal_op", 32'(illegal_op), 32'h1);

    // Load-use: one bubble, then the held instruction issues.
    cyc(6'h23, 5'd1, 5'd8, 1'b0);
    cyc(6'h00, 5'd8, 5'd9, 1'b0);
    check("loaduse stall", 32'(stall), 32'h1);
    check("loaduse control", 32'(control), 32'h0);
    cyc(6'h00, 5'd8, 5'd9, 1'b0);
    check("loaduse after stall", 32'(stall), 32'h0);
    check("loaduse after control", 32'(control), 32'h108);
    check("loaduse stall_count", 32'(stall_count), 32'h1);

    // Load to r0 never stalls.
    cyc(6'h23, 5'd1, 5'd0, 1'b0);
    cyc(6'h00, 5'd0, 5'd0, 1'b0);
    check("r0 stall", 32'(stall), 32'h0);
    check("r0 control", 32'(control), 32'h108);

    // Taken branch: four flush cycles, then normal decode.
    cyc(6'h00, 5'd1, 5'd2, 1'b1);
    check("br flush 0", 32'(flush), 32'h1);
    check("br control 0", 32'(control), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      cyc(6'h00, 5'd1, 5'd2, 1'b0);
      check("br flush window", 32'(flush), 32'h1);
      check("br control window", 32'(control), 32'h0);
    end
    cyc(6'h00, 5'd1, 5'd2, 1'b0);
    check("br flush end", 32'(flush), 32'h0);
    check("br control end", 32'(control), 32'h108);
    check("br flush_count", 32'(flush_count), 32'h1);

    // Branch wins over a simultaneous hazard.
    cyc(6'h23, 5'd1, 5'd10, 1'b0);
    cyc(6'h00, 5'd10, 5'd11, 1'b1);
    check("prio flush", 32'(flush), 32'h1);
    check("prio stall", 32'(stall), 32'h0);
    for (int i = 0; i < 3; i++) cyc(6'h00, 5'd10, 5'd11, 1'b0);
    cyc(6'h00, 5'd10, 5'd11, 1'b0);
    check("prio stall_count", 32'(stall_count), 32'h1);
    check("prio flush_count", 32'(flush_count), 32'h2);

    // Reset in the second flush cycle.
    cyc(6'h00, 5'd1, 5'd2, 1'b1);
    cyc(6'h00, 5'd1, 5'd2, 1'b0);
    check("midflush flush", 32'(flush), 32'h1);
    reset = 1'b1;
    #1;
    check("midflush rst flush", 32'(flush), 32'h0);
    check("midflush rst control", 32'(control), 32'h0);
    check("midflush rst stall_count", 32'(stall_count), 32'h0);
    check("midflush rst flush_count", 32'(flush_count), 32'h0);
    #1;
    reset = 1'b0;
    cyc(6'h00, 5'd1, 5'd2, 1'b0);
    check("postrst flush", 32'(flush), 32'h0);
    check("postrst control", 32'(control), 32'h108);

    // Saturation: the 2-bit instance pins at 3 while the 16-bit one keeps counting.
    for (int i = 0; i < 5; i++) begin
      cyc(6'h23, 5'd1, 5'd8, 1'b0);
      cyc(6'h00, 5'd8, 5'd9, 1'b0);
      check("sat stall", 32'(stall_s), 32'h1);
      cyc(6'h00, 5'd8, 5'd9, 1'b0);
    end
    check("sat stall_count wide", 32'(stall_count), 32'h5);
    check("sat stall_count narrow", 32'(stall_count_s), 32'h3);
    for (int i = 0; i < 4; i++) begin
      cyc(6'h00, 5'd1, 5'd2, 1'b1);
      for (int j = 0; j < 3; j++) cyc(6'h00, 5'd1, 5'd2, 1'b0);
    end
    cyc(6'h00, 5'd1, 5'd2, 1'b0);
    check("sat flush_count wide", 32'(flush_count), 32'h4);
    check("sat flush_count narrow", 32'(flush_count_s), 32'h3);
    check("sat final control", 32'(control_s), 32'h108);

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
